alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters (fetch/branch unit, execute stage, address generator, debug port).
- Arbitrates round-robin and registers the winning operation onto the ALU inputs.
- Captures result and compare flag one cycle later and returns them on a shared response channel tagged with the requester id.
- Rejects opcodes the ALU does not define (9-15) without using the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; must equal the global data width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester id; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  4*NUM_REQ  per-requester ALU opcode, requester i at [4*i+:4].
- req_a  in  DATA_WIDTH*NUM_REQ  per-requester operand 1.
- req_b  in  DATA_WIDTH*NUM_REQ  per-requester operand 2.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- alu_op  out  4  to ALU opcode.
- alu_data1  out  DATA_WIDTH  to ALU operand 1.
- alu_data2  out  DATA_WIDTH  to ALU operand 2.
- alu_result  in  DATA_WIDTH  from ALU.
- alu_compare  in  1  from ALU (data1 == data2).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_WIDTH  requester index of response.
- rsp_result  out  DATA_WIDTH  captured result.
- rsp_compare  out  1  captured compare flag.
- rsp_err  out  1  opcode was illegal (9-15).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, rr_ptr=0.
  - Reset values: req_ready=0, alu_op=0, alu_data1=0, alu_data2=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_compare=0, rsp_err=0, busy=0.
  - Reset mid-operation discards the in-flight request; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[winner]=1 combinationally in this cycle only; the request is transferred when valid and ready are both high.
  - On transfer: register alu_op/alu_data1/alu_data2 from the winner's fields, latch win_id, latch illegal = (op > 8); next state EXEC.
  - If no request: stay in IDLE, ALU inputs hold their last values.
- EXEC (exactly one cycle):
  - ALU settles on the registered inputs.
  - At the clock edge: rsp_result=alu_result, rsp_compare=alu_compare, rsp_id=win_id, rsp_err=0, rsp_valid=1; next state RESP.
  - If illegal: rsp_result=0, rsp_compare=0, rsp_err=1, and alu_op is forced to 7 (pass data1) so the ALU never sees an undefined opcode.
- RESP:
  - rsp_* held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0 next cycle, rr_ptr=(win_id+1) mod NUM_REQ, next state IDLE.
  - No new request is accepted in the RESP cycle, even if the response handshake completes in that cycle.
- Latency and throughput:
  - Accept edge to rsp_valid high: 1 cycle.
  - Minimum 3 cycles per operation (IDLE accept, EXEC, RESP with rsp_ready=1).
- req_ready is 0 in EXEC and RESP; requesters hold their request until accepted.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- rr_ptr advances only on response completion, never on illegal-free idle cycles.
- Arithmetic follows the ALU exactly: ADD/SUB wrap modulo 2^DATA_WIDTH; the controller never modifies operands or result.
- Simultaneous events:
  - Requests arriving in EXEC/RESP are deferred to the next IDLE.
  - A requester that drops req_valid before its grant is simply skipped.

Test Plan:
- Single request: reset, requester 1 issues op=0, a=5, b=7 -> req_ready[1] pulses 1 cycle; rsp_valid 1 cycle later with rsp_id=1, result=12, compare=0, err=0.
- Round-robin: all 4 valid continuously with op=1 and a=i+10, b=i -> grant order 0,1,2,3,0; each result=10; no requester granted twice before all others are served.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready stays 0, busy=1; raising rsp_ready returns FSM to IDLE the next cycle.
- Illegal opcode: requester 2 op=12, a=3, b=3 -> rsp_err=1, result=0, compare=0, alu_op observed as 7; rr_ptr advances to 3.
- Wrap and compare: op=0, a=0xFFFFFFFF, b=1 -> result=0, compare=0; then op=8, a=b=0x1234 -> result=0x1234, compare=1.
- Reset mid-operation: assert rst_n=0 during EXEC -> all outputs go to reset values immediately; no response is issued after release; the next request is granted from requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
//----------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one combinational ALU among NUM_REQ
//               requesters, with a tagged response channel.  Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [4*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [3:0]                    alu_op,
    output logic [DATA_WIDTH-1:0]         alu_data1,
    output logic [DATA_WIDTH-1:0]         alu_data2,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_compare,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_compare,
    output logic                          rsp_err,
    output logic                          busy
);

    localparam logic [3:0] OP_MAX_LEGAL = 4'd8;
    localparam logic [3:0] OP_PASS_A    = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_win_id;
    logic                  r_illegal;

    logic                  w_found;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_id;
    logic [3:0]            w_op;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_illegal;

    // Visit requesters in order rr_ptr, rr_ptr+1, ... with wrap; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_id    = '0;
        w_op    = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req_valid[j] &&
                    ((int'(r_rr_ptr) + k == j) || (int'(r_rr_ptr) + k - NUM_REQ == j))) begin
                    w_found    = 1'b1;
                    w_grant[j] = 1'b1;
                    w_id       = ID_WIDTH'(j);
                    w_op       = req_op[4*j +: 4];
                    w_a        = req_a[DATA_WIDTH*j +: DATA_WIDTH];
                    w_b        = req_b[DATA_WIDTH*j +: DATA_WIDTH];
                end
            end
        end
    end

    assign w_illegal = (w_op > OP_MAX_LEGAL);
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_win_id    <= '0;
            r_illegal   <= 1'b0;
            alu_op      <= '0;
            alu_data1   <= '0;
            alu_data2   <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_compare <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        // Undefined opcodes are replaced so the ALU only sees legal ops.
                        alu_op    <= w_illegal ? OP_PASS_A : w_op;
                        alu_data1 <= w_a;
                        alu_data2 <= w_b;
                        r_win_id  <= w_id;
                        r_illegal <= w_illegal;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= r_win_id;
                    if (r_illegal) begin
                        rsp_result  <= '0;
                        rsp_compare <= 1'b0;
                        rsp_err     <= 1'b1;
                    end else begin
                        rsp_result  <= alu_result;
                        rsp_compare <= alu_compare;
                        rsp_err     <= 1'b0;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_rr_ptr  <= (r_win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_win_id + 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//----------------------------------------------------------------------------
// tb_alu_arbiter : directed scoreboard bench for alu_arbiter. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [4*NR-1:0]   req_op;
    logic [DW*NR-1:0]  req_a;
    logic [DW*NR-1:0]  req_b;
    logic [NR-1:0]     req_ready;
    logic [3:0]        alu_op;
    logic [DW-1:0]     alu_data1;
    logic [DW-1:0]     alu_data2;
    logic [DW-1:0]     alu_result;
    logic              alu_compare;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_result;
    logic              rsp_compare;
    logic              rsp_err;
    logic              busy;

    logic [3:0]        f_op [NR];
    logic [DW-1:0]     f_a  [NR];
    logic [DW-1:0]     f_b  [NR];

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] res;
        logic          cmp;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_result(alu_result), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_compare(rsp_compare), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_op[4*i +: 4]  = f_op[i];
            req_a[DW*i +: DW] = f_a[i];
            req_b[DW*i +: DW] = f_b[i];
        end
    end

    // Reference combinational ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 pass a, 8 pass b.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0: alu_result = alu_data1 + alu_data2;
            4'd1: alu_result = alu_data1 - alu_data2;
            4'd2: alu_result = alu_data1 & alu_data2;
            4'd3: alu_result = alu_data1 | alu_data2;
            4'd4: alu_result = alu_data1 ^ alu_data2;
            4'd5: alu_result = alu_data1 << alu_data2[4:0];
            4'd6: alu_result = alu_data1 >> alu_data2[4:0];
            4'd7: alu_result = alu_data1;
            4'd8: alu_result = alu_data2;
            default: alu_result = '0;
        endcase
        alu_compare = (alu_data1 == alu_data2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_id), 64'hFF);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    check("rsp_id",      64'(rsp_id),      64'(e.id));
                    check("rsp_result",  64'(rsp_result),  64'(e.res));
                    check("rsp_compare", 64'(rsp_compare), 64'(e.cmp));
                    check("rsp_err",     64'(rsp_err),     64'(e.err));
                end
            end
        end
    end

    task automatic push(input int id, input logic [DW-1:0] res, input logic cmp, input logic err);
        rsp_t e;
        e.id  = IW'(id);
        e.res = res;
        e.cmp = cmp;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        f_op[id] = op;
        f_a[id]  = a;
        f_b[id]  = b;
        req_valid[id] = 1'b1;
    endtask

    task automatic clr_req(input int id);
        req_valid[id] = 1'b0;
    endtask

    // Entered and left at posedge+1; returns just after the accepting edge.
    task automatic expect_grant(input int id);
        logic [NR-1:0] exp_g;
        bit seen;
        exp_g = '0;
        exp_g[id] = 1'b1;
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1;
                check("grant", 64'(req_ready), 64'(exp_g));
            end
            @(posedge clk);
            #1;
        end
        if (!seen) check("grant_timeout", 64'(req_ready), 64'(exp_g));
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int n = 0; n < 30 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) check("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            f_op[i] = '0;
            f_a[i]  = '0;
            f_b[i]  = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_alu_op",    64'(alu_op),    64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request
        set_req(1, 4'd0, 32'd5, 32'd7);
        push(1, 32'd12, 1'b0, 1'b0);
        expect_grant(1);
        clr_req(1);
        @(negedge clk);
        check("single_ready_pulse", 64'(req_ready), 64'd0);
        check("single_busy_exec",   64'(busy),      64'd1);
        check("single_no_early",    64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("single_latency",     64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // Round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 4'd1, DW'(i + 10), DW'(i));
        for (int n = 0; n < 5; n++) push(n % NR, 32'd10, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) expect_grant(n % NR);
        req_valid = '0;
        wait_idle();

        // Backpressure, with a request waiting behind the stalled response
        rsp_ready = 1'b0;
        set_req(3, 4'd0, 32'd1, 32'd2);
        push(3, 32'd3, 1'b0, 1'b0);
        expect_grant(3);
        clr_req(3);
        set_req(0, 4'd0, 32'd10, 32'd20);
        push(0, 32'd30, 1'b0, 1'b0);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        if (!got) check("bp_rsp_timeout", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",  64'(rsp_valid),  64'd1);
            check("bp_id",     64'(rsp_id),     64'd3);
            check("bp_result", 64'(rsp_result), 64'd3);
            check("bp_ready",  64'(req_ready),  64'd0);
            check("bp_busy",   64'(busy),       64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy",  64'(busy),      64'd0);
        check("bp_idle_grant", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        clr_req(0);
        wait_idle();

        // Illegal opcode from requester 2
        set_req(2, 4'd12, 32'd3, 32'd3);
        push(2, 32'd0, 1'b0, 1'b1);
        expect_grant(2);
        clr_req(2);
        @(negedge clk);
        check("illegal_alu_op", 64'(alu_op), 64'd7);
        @(posedge clk);
        #1;
        wait_idle();

        // Pointer now 3: requester 3 beats 0; add wrap then pass-with-compare
        set_req(3, 4'd0, 32'hFFFF_FFFF, 32'd1);
        set_req(0, 4'd8, 32'h1234, 32'h1234);
        push(3, 32'd0, 1'b0, 1'b0);
        push(0, 32'h1234, 1'b1, 1'b0);
        expect_grant(3);
        clr_req(3);
        expect_grant(0);
        clr_req(0);
        wait_idle();

        // Reset during EXEC
        set_req(1, 4'd0, 32'd9, 32'd9);
        expect_grant(1);
        clr_req(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready),  64'd0);
        check("mid_rst_alu_op",    64'(alu_op),     64'd0);
        check("mid_rst_data1",     64'(alu_data1),  64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid),  64'd0);
        check("mid_rst_rsp_id",    64'(rsp_id),     64'd0);
        check("mid_rst_result",    64'(rsp_result), 64'd0);
        check("mid_rst_compare",   64'(rsp_compare), 64'd0);
        check("mid_rst_busy",      64'(busy),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        set_req(3, 4'd1, 32'd2, 32'd5);
        set_req(0, 4'd0, 32'd2, 32'd2);
        push(0, 32'd4, 1'b1, 1'b0);
        push(3, 32'hFFFF_FFFD, 1'b0, 1'b0);
        expect_grant(0);
        clr_req(0);
        expect_grant(3);
        clr_req(3);
        wait_idle();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
